// File: rtl/ir_fetch_unit.sv
// Instruction-fetch sequencer: reads NBYTES memory words (first word lands in the
// most significant slot), commits them atomically to ir_out and advances the PC.
module ir_fetch_unit #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int NBYTES   = 2,
  parameter int PC_RESET = 0,
  localparam int IR_W    = NBYTES * DATA_W,
  localparam int IDX_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_cs,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [IR_W-1:0]   ir_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  byte_idx
);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t                         state, state_nxt;
  logic [ADDR_W-1:0]              pc;
  logic [NBYTES-1:0][DATA_W-1:0]  shadow, merged, ir_q;
  logic                           capture, last;

  // A branch outranks a ready word in the same cycle.
  assign capture = (state == FETCH) && mem_ready && !branch_valid;
  assign last    = (byte_idx == IDX_W'(NBYTES - 1));

  // Shadow with the current word merged in; also the value committed on the last word.
  for (genvar g = 0; g < NBYTES; g++) begin : g_word
    assign merged[g] = (capture && ((NBYTES - 1 - g) == int'(byte_idx))) ? mem_rdata : shadow[g];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH: begin
        if (branch_valid)        state_nxt = IDLE;
        else if (capture && last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_cs = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      FETCH: begin
        mem_cs = 1'b1;
        busy   = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= ADDR_W'(PC_RESET);
      byte_idx <= '0;
      shadow   <= '0;
      ir_q     <= '0;
    end else begin
      shadow <= merged;
      if (branch_valid) pc <= branch_addr;
      else if (capture) pc <= pc + 1'b1;
      if ((state == IDLE && start) || (state == FETCH && branch_valid) || (capture && last))
        byte_idx <= '0;
      else if (capture)
        byte_idx <= byte_idx + 1'b1;
      if (capture && last) ir_q <= merged;
    end
  end

  assign mem_addr = pc;
  assign pc_out   = pc;
  assign ir_out   = ir_q;

endmodule

// File: tb/tb_ir_fetch_unit.sv
// Bench for ir_fetch_unit: two instances (2-word/8-bit PC and 3-word/10-bit PC) share
// stimulus; a transaction-level model is compared every cycle, plus literal checks.
module tb_ir_fetch_unit;
  logic        clk, reset, start, branch_valid, mem_ready;
  logic [9:0]  branch_addr;
  logic [7:0]  mem_addr_a, rdata_a, pc_a;
  logic [15:0] ir_a;
  logic        cs_a, busy_a, done_a;
  logic [0:0]  idx_a;
  logic [9:0]  mem_addr_b, pc_b;
  logic [7:0]  rdata_b;
  logic [23:0] ir_b;
  logic        cs_b, busy_b, done_b;
  logic [1:0]  idx_b;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [1024];
  assign rdata_a = mem0[mem_addr_a];
  assign rdata_b = mem1[mem_addr_b];

  int errors = 0, checks = 0;

  ir_fetch_unit #(.DATA_W(8), .ADDR_W(8), .NBYTES(2), .PC_RESET(0)) dut_a (
    .clk(clk), .reset(reset), .start(start), .branch_valid(branch_valid),
    .branch_addr(branch_addr[7:0]), .mem_addr(mem_addr_a), .mem_cs(cs_a),
    .mem_rdata(rdata_a), .mem_ready(mem_ready), .ir_out(ir_a), .pc_out(pc_a),
    .busy(busy_a), .done(done_a), .byte_idx(idx_a));

  ir_fetch_unit #(.DATA_W(8), .ADDR_W(10), .NBYTES(3), .PC_RESET(10'h3FE)) dut_b (
    .clk(clk), .reset(reset), .start(start), .branch_valid(branch_valid),
    .branch_addr(branch_addr), .mem_addr(mem_addr_b), .mem_cs(cs_b),
    .mem_rdata(rdata_b), .mem_ready(mem_ready), .ir_out(ir_b), .pc_out(pc_b),
    .busy(busy_b), .done(done_b), .byte_idx(idx_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: phase 0 idle / 1 fetching / 2 done; words are accumulated MSB-first.
  int     m_phase [2], m_pc [2], m_cnt [2];
  longint m_acc [2], m_ir [2];
  bit     m_ok = 0;
  int     nw [2]    = '{2, 3};
  int     amask [2] = '{255, 1023};
  int     pcr [2]   = '{0, 10'h3FE};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int ph, pc, cnt, ba, word;
      longint acc, ir;
      ph = m_phase[i]; pc = m_pc[i]; cnt = m_cnt[i]; acc = m_acc[i]; ir = m_ir[i];
      ba = int'(branch_addr) & amask[i];
      if (reset) begin
        ph = 0; pc = pcr[i]; cnt = 0; acc = 0; ir = 0;
      end else if (ph == 0) begin
        if (branch_valid) pc = ba;
        if (start) begin ph = 1; cnt = 0; acc = 0; end
      end else if (ph == 1) begin
        if (branch_valid) begin pc = ba; ph = 0; cnt = 0; end
        else if (mem_ready) begin
          word = (i == 0) ? int'(mem0[pc]) : int'(mem1[pc]);
          acc  = acc * 256 + word;
          pc   = (pc + 1) & amask[i];
          cnt  = cnt + 1;
          if (cnt == nw[i]) begin ir = acc; ph = 2; cnt = 0; end
        end
      end else begin
        if (branch_valid) pc = ba;
        ph = 0;
      end
      m_phase[i] <= ph; m_pc[i] <= pc; m_cnt[i] <= cnt; m_acc[i] <= acc; m_ir[i] <= ir;
    end
    if (reset) m_ok <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("a_mem_addr", mem_addr_a, m_pc[0]);
      chk("a_pc",       pc_a,       m_pc[0]);
      chk("a_mem_cs",   cs_a,       m_phase[0] == 1);
      chk("a_busy",     busy_a,     m_phase[0] != 0);
      chk("a_done",     done_a,     m_phase[0] == 2);
      chk("a_ir",       ir_a,       m_ir[0]);
      chk("a_byte_idx", idx_a,      m_cnt[0]);
      chk("b_mem_addr", mem_addr_b, m_pc[1]);
      chk("b_mem_cs",   cs_b,       m_phase[1] == 1);
      chk("b_busy",     busy_b,     m_phase[1] != 0);
      chk("b_done",     done_b,     m_phase[1] == 2);
      chk("b_ir",       ir_b,       m_ir[1]);
      chk("b_byte_idx", idx_b,      m_cnt[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, cs;
    bit seen;
    bit [5:0] pat = 6'b100100;
    for (int i = 0; i < 256; i++)  mem0[i] = 8'h00;
    for (int i = 0; i < 1024; i++) mem1[i] = 8'h00;
    mem0[0] = 8'hA5; mem0[1] = 8'h3C;
    mem1[10'h3FE] = 8'h11; mem1[10'h3FF] = 8'h22; mem1[0] = 8'h33;
    reset = 1; start = 0; branch_valid = 0; branch_addr = '0; mem_ready = 1;
    step(); step();
    reset = 0;
    chk("rst_pc_a", pc_a, 0);
    chk("rst_ir_a", ir_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_pc_b", pc_b, 10'h3FE);

    // Zero-wait fetch
    start = 1; step(); start = 0; n = 1; cs = 0;
    while (!done_a && n < 40) begin
      if (cs_a) cs++;
      step(); n++;
    end
    chk("t1_latency", n, 3);
    chk("t1_cs_cycles", cs, 2);
    chk("t1_ir_a", ir_a, 16'hA53C);
    chk("t1_pc_a", pc_a, 2);
    step();
    chk("t1_done_b", done_b, 1);
    chk("t1_ir_b", ir_b, 24'h112233);
    chk("t1_pc_b", pc_b, 10'h001);
    step();

    // Two wait states before each word
    reset = 1; step(); reset = 0;
    start = 1; mem_ready = 0; step(); start = 0;
    for (int i = 0; i < 6; i++) begin
      mem_ready = pat[i];
      chk("t2_addr_hold", mem_addr_a, (i < 3) ? 0 : 1);
      step();
    end
    chk("t2_done", done_a, 1);
    chk("t2_ir_a", ir_a, 16'hA53C);
    chk("t2_pc_a", pc_a, 2);
    mem_ready = 1;
    step(); step(); step();

    // Branch aborts a half-finished fetch
    seen = 0;
    start = 1; step(); start = 0; seen |= done_a;
    step(); seen |= done_a;
    branch_valid = 1; branch_addr = 10'h040; step(); branch_valid = 0; seen |= done_a;
    chk("t3_busy", busy_a, 0);
    chk("t3_pc", pc_a, 8'h40);
    chk("t3_ir_kept", ir_a, 16'hA53C);
    step(); seen |= done_a;
    chk("t3_no_done", seen, 0);

    // start + branch together, PC wraps
    mem0[8'hFF] = 8'h12; mem0[0] = 8'h34;
    start = 1; branch_valid = 1; branch_addr = 10'h0FF; step();
    start = 0; branch_valid = 0;
    step(); step();
    chk("t4_done", done_a, 1);
    chk("t4_ir", ir_a, 16'h1234);
    chk("t4_pc_wrap", pc_a, 1);
    step(); step(); step();

    // Reset mid-fetch, then start during DONE
    start = 1; step(); start = 0; step();
    chk("t5_busy_mid", busy_a, 1);
    reset = 1; step(); reset = 0;
    chk("t5_rst_busy", busy_a, 0);
    chk("t5_rst_pc", pc_a, 0);
    chk("t5_rst_ir", ir_a, 0);
    chk("t5_rst_pc_b", pc_b, 10'h3FE);
    start = 1; step(); start = 0; step(); step();
    chk("t5_done", done_a, 1);
    start = 1; step(); start = 0;
    chk("t5_no_refetch0", busy_a, 0);
    step();
    chk("t5_no_refetch1", busy_a, 0);
    step(); step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
